// File: rtl/sdram_responder_if.sv
// sdram_responder_if: 8-bit SDRAM bus between a RAM controller and the
// sdram_responder device model.
//   master : controller side (drives command/address/mask/write data)
//   slave  : device side (drives read data and its output enable)
// Signals: nCS/nRAS/nCAS/nRWE command lines, CKE clock enable, RBA bank,
// RA address, DQMH/DQML active-low lane masks, RD_I write data,
// RD_O read data, RD_OE read data drive enable.
interface sdram_responder_if;
    logic        nCS;
    logic        nRAS;
    logic        nCAS;
    logic        nRWE;
    logic        CKE;
    logic [1:0]  RBA;
    logic [12:0] RA;
    logic        DQMH;
    logic        DQML;
    logic [7:0]  RD_I;
    logic [7:0]  RD_O;
    logic        RD_OE;

    modport master (
        output nCS, nRAS, nCAS, nRWE, CKE, RBA, RA, DQMH, DQML, RD_I,
        input  RD_O, RD_OE
    );

    modport slave (
        input  nCS, nRAS, nCAS, nRWE, CKE, RBA, RA, DQMH, DQML, RD_I,
        output RD_O, RD_OE
    );
endinterface

// File: rtl/sdram_responder.sv
// sdram_responder: synthesizable SDRAM device model for the far end of the
// 8-bit SDRAM bus. Decodes ACT/RD/WR/PRE/AREF/LMR, tracks per-bank open rows,
// serves byte reads/writes from a 16-bit word array with DQMH/DQML lane
// selection, and raises sticky protocol-error flags.
// Ports:
//   C8M    - clock, all logic on rising edge
//   RESET  - synchronous active-high reset (array contents are kept)
//   bus    - sdram_responder_if.slave (commands in, read data out)
//   ERR    - sticky errors: [0] bank state, [1] access before mode set,
//            [2] bad mode word, [3] read with both lanes enabled
//   REFCNT - saturating auto-refresh counter

// Per-bank IDLE/ACTIVE tracker with the open row register.
module sdram_bank #(
    parameter int ROW_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                act,
    input  logic                pre,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                active,
    output logic [ROW_BITS-1:0] row
);
    typedef enum logic {B_IDLE, B_ACTIVE} bank_state_t;

    bank_state_t state, state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= B_IDLE;
            row   <= '0;
        end else begin
            state <= state_nx;
            // ACT to an already open bank keeps the old row
            if (act && state == B_IDLE) row <= row_in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            B_IDLE:   if (act) state_nx = B_ACTIVE;
            B_ACTIVE: if (pre) state_nx = B_IDLE;
            default:  state_nx = B_IDLE;
        endcase
    end

    assign active = (state == B_ACTIVE);
endmodule

module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 5
) (
    input  logic                C8M,
    input  logic                RESET,
    sdram_responder_if.slave    bus,
    output logic [3:0]          ERR,
    output logic [15:0]         REFCNT
);
    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 2 + ROW_BITS + COL_BITS;
    localparam int STAGES    = 2;   // max CL - 1 internal stages ahead of the output

    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_AREF, C_LMR} cmd_t;

    cmd_t cmd;
    logic ckep;
    logic run;
    logic mode_ok;
    logic [1:0] cl;

    logic [NUM_BANKS-1:0]               bank_active;
    logic [NUM_BANKS-1:0]               bank_act;
    logic [NUM_BANKS-1:0]               bank_pre;
    logic [NUM_BANKS-1:0][ROW_BITS-1:0] bank_row;

    logic                any_active;
    logic                sel_active;
    logic [ROW_BITS-1:0] sel_row;
    logic                access_ok;
    logic                lmr_legal;
    logic [ADDR_W-1:0]   addr;
    logic                wr_go;
    logic                rd_go;
    logic                rd_pulse;
    logic [15:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [1:0]          cl_slot;
    logic [3:0]          err_set;

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    logic [STAGES:0]      vld_pipe;
    logic [STAGES:0][7:0] dat_pipe;

    logic unused_ra;
    assign unused_ra = ^bus.RA;

    // A registered-low CKE suspends the following edge entirely.
    assign run = ckep;

    always_comb begin
        cmd = C_NOP;
        if (!bus.nCS) begin
            case ({bus.nRAS, bus.nCAS, bus.nRWE})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_RD;
                3'b100:  cmd = C_WR;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_AREF;
                3'b000:  cmd = C_LMR;
                default: cmd = C_NOP;  // NOP and burst-stop
            endcase
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_act[b] = run && cmd == C_ACT && bus.RBA == 2'(b);
            bank_pre[b] = run && cmd == C_PRE && (bus.RA[10] || bus.RBA == 2'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sdram_bank #(.ROW_BITS(ROW_BITS)) u_bank (
            .clk    (C8M),
            .rst    (RESET),
            .act    (bank_act[b]),
            .pre    (bank_pre[b]),
            .row_in (bus.RA[ROW_BITS-1:0]),
            .active (bank_active[b]),
            .row    (bank_row[b])
        );
    end

    assign any_active = |bank_active;
    assign sel_active = bank_active[bus.RBA];
    assign sel_row    = bank_row[bus.RBA];
    assign access_ok  = sel_active && mode_ok;
    assign lmr_legal  = (bus.RA[6:4] == 3'd2 || bus.RA[6:4] == 3'd3) && bus.RA[2:0] == 3'd0;
    assign addr       = {bus.RBA, sel_row, bus.RA[COL_BITS-1:0]};

    assign wr_go    = !RESET && run && cmd == C_WR && access_ok;
    assign rd_go    = run && cmd == C_RD && access_ok;
    assign rd_pulse = rd_go && !(bus.DQMH && bus.DQML);
    assign rd_word  = mem[addr];
    // Both lanes enabled resolves to the low byte.
    assign rd_byte  = !bus.DQML ? rd_word[7:0] : rd_word[15:8];
    // Entry slot so the byte reaches the output stage after CL-1 more edges.
    assign cl_slot  = cl - 2'd1;

    always_comb begin
        err_set = 4'b0000;
        if (run) begin
            case (cmd)
                C_ACT:  err_set[0] = sel_active;
                C_RD, C_WR: begin
                    err_set[0] = !sel_active;
                    err_set[1] = !mode_ok;
                    err_set[3] = cmd == C_RD && access_ok && !bus.DQMH && !bus.DQML;
                end
                C_AREF: err_set[0] = any_active;
                C_LMR: begin
                    err_set[0] = any_active;
                    err_set[2] = !any_active && !lmr_legal;
                end
                default: err_set = 4'b0000;
            endcase
        end
    end

    // Array is not reset; writes land on the command edge.
    always_ff @(posedge C8M) begin
        if (wr_go) begin
            if (!bus.DQML) mem[addr][7:0]  <= bus.RD_I;
            if (!bus.DQMH) mem[addr][15:8] <= bus.RD_I;
        end
    end

    always_ff @(posedge C8M) begin
        if (RESET) begin
            ckep     <= 1'b1;
            vld_pipe <= '0;
            dat_pipe <= '0;
            ERR      <= 4'b0000;
            REFCNT   <= 16'h0000;
            mode_ok  <= 1'b0;
            cl       <= 2'd2;
        end else begin
            ckep <= bus.CKE;
            if (run) begin
                ERR <= ERR | err_set;
                if (cmd == C_AREF && !any_active && REFCNT != 16'hFFFF)
                    REFCNT <= REFCNT + 16'd1;
                if (cmd == C_LMR && !any_active && lmr_legal) begin
                    cl      <= bus.RA[5:4];
                    mode_ok <= 1'b1;
                end
                // Output stage holds its byte when no pulse is due.
                vld_pipe[0] <= vld_pipe[1];
                if (vld_pipe[1]) dat_pipe[0] <= dat_pipe[1];
                for (int s = 1; s < STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s+1];
                    dat_pipe[s] <= dat_pipe[s+1];
                end
                vld_pipe[STAGES] <= 1'b0;
                if (rd_pulse) begin
                    vld_pipe[cl_slot] <= 1'b1;
                    dat_pipe[cl_slot] <= rd_byte;
                end
            end
        end
    end

    assign bus.RD_OE = vld_pipe[0];
    assign bus.RD_O  = dat_pipe[0];
endmodule
